// File: rtl/magia_tile_pkg.sv
// Shared MAGIA tile definitions: core OBI data-port structs and iDMA control defaults.
package magia_tile_pkg;

    localparam int unsigned CORE_OBI_AW = 32;
    localparam int unsigned CORE_OBI_DW = 32;
    localparam int unsigned CORE_OBI_IDW = 4;

    localparam int unsigned IDMA_CTRL_TIMEOUT_CYCLES = 256;

    typedef struct packed {
        logic [CORE_OBI_AW-1:0]   addr;
        logic                     we;
        logic [CORE_OBI_DW/8-1:0] be;
        logic [CORE_OBI_DW-1:0]   wdata;
        logic [CORE_OBI_IDW-1:0]  aid;
    } core_obi_data_a_t;

    typedef struct packed {
        logic [CORE_OBI_DW-1:0]  rdata;
        logic                    err;
        logic [CORE_OBI_IDW-1:0] rid;
        logic                    r_optional;
    } core_obi_data_r_t;

    typedef struct packed {
        logic             req;
        core_obi_data_a_t a;
    } core_obi_data_req_t;

    typedef struct packed {
        logic             gnt;
        logic             rvalid;
        core_obi_data_r_t r;
    } core_obi_data_rsp_t;

endpackage

// File: rtl/idma_obi_ctrl_req_serializer.sv
// Registered OBI slave stage in front of the combinational iDMA control decoder:
// holds one access steady until answered, with a timeout that turns hangs into errors.
module idma_obi_ctrl_req_serializer
    import magia_tile_pkg::*;
#(
    parameter type         obi_req_t      = core_obi_data_req_t,
    parameter type         obi_rsp_t      = core_obi_data_rsp_t,
    parameter int unsigned TIMEOUT_CYCLES = IDMA_CTRL_TIMEOUT_CYCLES
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t core_obi_req_i,
    output obi_rsp_t core_obi_rsp_o,
    output obi_req_t dec_obi_req_o,
    input  obi_rsp_t dec_obi_rsp_i,
    output logic     busy_o,
    output logic     timeout_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } idma_ctrl_ser_state_e;

    idma_ctrl_ser_state_e state_q, state_d;
    obi_req_t             req_q;
    obi_rsp_t             rsp_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 core_gnt;
    logic                 dec_hit;
    logic                 tmo;

    always_comb begin
        state_d        = state_q;
        core_gnt       = 1'b0;
        dec_hit        = 1'b0;
        tmo            = 1'b0;
        core_obi_rsp_o = '0;
        dec_obi_req_o  = '0;
        unique case (state_q)
            IDLE: begin
                core_gnt = core_obi_req_i.req;
                if (core_gnt) state_d = ISSUE;
            end
            ISSUE: begin
                dec_obi_req_o     = req_q;
                dec_obi_req_o.req = 1'b1;
                dec_hit = dec_obi_rsp_i.gnt & dec_obi_rsp_i.rvalid;
                // a decoder answer in the final cycle takes priority over the timeout
                tmo = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !dec_hit;
                if (dec_hit || tmo) state_d = RESP;
            end
            RESP: begin
                core_obi_rsp_o.rvalid = 1'b1;
                core_obi_rsp_o.r      = rsp_q.r;
                core_gnt = core_obi_req_i.req;
                state_d  = core_gnt ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // gnt is combinational from the request, so keep it quiet while reset is held
        core_obi_rsp_o.gnt = core_gnt & rst_ni;
    end

    assign busy_o    = (state_q != IDLE);
    assign timeout_o = tmo;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
            rsp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (core_gnt) begin
                req_q <= core_obi_req_i;
                cnt_q <= '0;
            end else if (state_q == ISSUE) begin
                if (dec_hit) begin
                    rsp_q.r.rdata <= dec_obi_rsp_i.r.rdata;
                    rsp_q.r.err   <= dec_obi_rsp_i.r.err;
                    rsp_q.r.rid   <= req_q.a.aid;
                end else if (tmo) begin
                    rsp_q.r.rdata <= '0;
                    rsp_q.r.err   <= 1'b1;
                    rsp_q.r.rid   <= req_q.a.aid;
                end else if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{req_q.req, rsp_q.gnt, rsp_q.rvalid,
                           dec_obi_rsp_i.r.rid, dec_obi_rsp_i.r.r_optional};

endmodule

// File: tb/tb_idma_obi_ctrl_req_serializer.sv
// Scoreboard bench: driver pushes expected responses at grant, monitor checks every cycle.
module tb_idma_obi_ctrl_req_serializer;
    import magia_tile_pkg::*;

    localparam int unsigned T = 8;
    localparam int NEVER = 1000;

    logic               clk = 1'b0;
    logic               rst_ni = 1'b0;
    core_obi_data_req_t core_req;
    core_obi_data_rsp_t core_rsp;
    core_obi_data_req_t dec_req;
    core_obi_data_rsp_t dec_rsp;
    logic               busy_o;
    logic               timeout_o;

    idma_obi_ctrl_req_serializer #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .core_obi_req_i (core_req),
        .core_obi_rsp_o (core_rsp),
        .dec_obi_req_o  (dec_req),
        .dec_obi_rsp_i  (dec_rsp),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // decoder plan, indexed by access number
    int          plan_delay [0:255];
    logic [31:0] plan_rdata [0:255];
    logic        plan_err   [0:255];
    int          n_issued = 0;
    int          n_granted = 0;
    int          dec_cnt = 0;
    int          pi;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_cnt <= 0;
        end else begin
            if (core_req.req && core_rsp.gnt) n_granted <= n_granted + 1;
            if (dec_req.req && !dec_rsp.gnt) dec_cnt <= dec_cnt + 1;
            else dec_cnt <= 0;
        end
    end

    always_comb begin
        dec_rsp = '0;
        pi = n_granted - 1;
        if (dec_req.req && pi >= 0 && dec_cnt == plan_delay[pi]) begin
            dec_rsp.gnt     = 1'b1;
            dec_rsp.rvalid  = 1'b1;
            dec_rsp.r.rdata = plan_rdata[pi];
            dec_rsp.r.err   = plan_err[pi];
            dec_rsp.r.rid   = 4'hF;
            dec_rsp.r.r_optional = 1'b1;
        end
    end

    typedef struct {
        core_obi_data_a_t a;
        logic [31:0]      rdata;
        logic             err;
        int               gnt_cyc;
        int               exp_cyc;
        bit               tmo;
    } exp_t;
    exp_t q[$];

    task automatic do_access(input logic [31:0] addr, input logic we, input logic [3:0] be,
                             input logic [31:0] wdata, input logic [3:0] aid, input int d,
                             input logic [31:0] rd, input logic er, input bit b2b);
        int   idx;
        bit   granted;
        exp_t e;
        idx = n_issued;
        plan_delay[idx] = d;
        plan_rdata[idx] = rd;
        plan_err[idx]   = er;
        n_issued++;
        core_req.req     = 1'b1;
        core_req.a.addr  = addr;
        core_req.a.we    = we;
        core_req.a.be    = be;
        core_req.a.wdata = wdata;
        core_req.a.aid   = aid;
        granted = 0;
        for (int c = 0; c < 60 && !granted; c++) begin
            @(negedge clk);
            if (core_rsp.gnt) granted = 1;
        end
        if (!granted) begin
            check("grant_wait", 128'd0, 128'd1);
        end else begin
            e.a       = core_req.a;
            e.tmo     = (d >= int'(T));
            e.rdata   = e.tmo ? 32'h0 : rd;
            e.err     = e.tmo ? 1'b1 : er;
            e.gnt_cyc = cyc;
            e.exp_cyc = cyc + (e.tmo ? int'(T) - 1 : d) + 2;
            q.push_back(e);
        end
        @(posedge clk); #1;
        if (!b2b) core_req.req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // monitor
    always begin
        @(negedge clk); #2;
        if (rst_ni) begin
            bit   have;
            bit   in_issue;
            bit   exp_rv;
            exp_t f;
            have = (q.size() > 0);
            if (have) f = q[0];
            in_issue = have && f.gnt_cyc < cyc && cyc < f.exp_cyc;
            check("busy", busy_o, have && f.gnt_cyc < cyc);
            check("dec_req", dec_req.req, in_issue);
            if (in_issue && dec_req.req) check("dec_a", dec_req.a, f.a);
            check("core_gnt", core_rsp.gnt, core_req.req && !in_issue);
            check("timeout", timeout_o, have && f.tmo && cyc == f.exp_cyc - 1);
            exp_rv = have && cyc == f.exp_cyc;
            check("rvalid", core_rsp.rvalid, exp_rv);
            if (exp_rv && core_rsp.rvalid) begin
                check("rdata", core_rsp.r.rdata, f.rdata);
                check("err", core_rsp.r.err, f.err);
                check("rid", core_rsp.r.rid, f.a.aid);
                check("r_optional", core_rsp.r.r_optional, 1'b0);
            end
            if (have && cyc >= f.exp_cyc) void'(q.pop_front());
        end
    end

    initial begin
        core_req = '0;
        rst_ni = 1'b0;
        #1;
        check("rst_core_rsp", core_rsp, '0);
        check("rst_dec_req", dec_req, '0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_timeout", timeout_o, 1'b0);
        idle(3);
        rst_ni = 1'b1;
        idle(2);

        // write CONFIG, answered in first ISSUE cycle
        do_access(32'h0001_0000, 1'b1, 4'hF, 32'h0000_0040, 4'd5, 0, 32'hDEAD_BEEF, 1'b0, 0);
        idle(3);
        // read LENGTH_LOW with 5-cycle frontend delay
        do_access(32'h0001_0010, 1'b0, 4'hF, 32'h0, 4'd6, 5, 32'h0000_1000, 1'b0, 0);
        idle(9);
        // undecoded offset: timeout
        do_access(32'h0001_00C8, 1'b0, 4'hF, 32'h0, 4'd7, NEVER, 32'h1234_5678, 1'b0, 0);
        idle(T + 4);
        // four back-to-back accesses
        for (int i = 1; i <= 4; i++)
            do_access(32'h0001_0004 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 4'(i), 0,
                      32'hA000_0000 + 32'(i), 1'b0, i != 4);
        idle(3);
        // reset during ISSUE of a read
        do_access(32'h0001_0020, 1'b0, 4'hF, 32'h0, 4'd9, 50, 32'h5555_AAAA, 1'b0, 0);
        idle(1);
        rst_ni = 1'b0;
        q.delete();
        #1;
        check("mid_rst_core_rsp", core_rsp, '0);
        check("mid_rst_dec_req", dec_req, '0);
        check("mid_rst_busy", busy_o, 1'b0);
        idle(2);
        rst_ni = 1'b1;
        idle(4);
        do_access(32'h0001_0024, 1'b0, 4'hF, 32'h0, 4'd10, 1, 32'h0BAD_F00D, 1'b1, 0);
        idle(4);
        // response lands in the timeout cycle
        do_access(32'h0001_0028, 1'b0, 4'hF, 32'h0, 4'd11, int'(T) - 1, 32'hCAFE_0001, 1'b0, 0);
        idle(T + 4);

        for (int i = 0; i < 40; i++) begin
            int r;
            bit b2b;
            r = $urandom_range(0, 11);
            b2b = (i != 39) && ($urandom_range(0, 1) == 1);
            do_access(32'h0001_0000 | 32'({$urandom_range(0, 63), 2'b00}), 1'($urandom),
                      4'($urandom), $urandom, 4'($urandom), (r == 11) ? NEVER : r,
                      $urandom, 1'($urandom), b2b);
            if (!b2b) idle($urandom_range(0, 2));
        end

        begin
            int w;
            w = 0;
            while (q.size() > 0 && w < 200) begin
                @(posedge clk);
                w++;
            end
            if (q.size() > 0) check("drain", 128'(q.size()), 128'd0);
        end
        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/idma_obi_ctrl_req_serializer.md
Name: idma_obi_ctrl_req_serializer

Overview:
- Registered OBI slave stage directly upstream of the iDMA OBI control decoder, which is purely combinational.
- Accepts core OBI accesses to the iDMA control window and holds each one steady towards the decoder until the iDMA register frontend answers.
- Returns a protocol-correct OBI response: rvalid strictly after the gnt cycle, with rid echoed.
- Converts hung or undecoded accesses into error responses through a timeout, so the core never deadlocks.

Parameters:
- obi_req_t, magia_tile_pkg::core_obi_data_req_t, OBI request struct (req, a.addr/we/be/wdata/aid).
- obi_rsp_t, magia_tile_pkg::core_obi_data_rsp_t, OBI response struct (gnt, rvalid, r.rdata/err/rid/r_optional).
- TIMEOUT_CYCLES, 256, maximum cycles in ISSUE before an error response; 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived, not overridden).

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- core_obi_req_i  in  obi_req_t  request from the core data crossbar.
- core_obi_rsp_o  out  obi_rsp_t  response to the core.
- dec_obi_req_o  out  obi_req_t  held request to the idma_obi_ctrl_decoder.
- dec_obi_rsp_i  in  obi_rsp_t  decoder response (gnt and rvalid combinational).
- busy_o  out  1  high while an access is captured and unanswered (ISSUE or RESP).
- timeout_o  out  1  one-cycle pulse when an access is terminated by timeout.

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - state=IDLE; all captured registers and the counter cleared.
  - core_obi_rsp_o and dec_obi_req_o all-zero; busy_o=0; timeout_o=0.
  - A reset mid-access drops that access silently; no response is issued after reset release.
- State IDLE:
  - core gnt = core req (combinational).
  - On req&gnt, capture addr, we, be, wdata, aid; clear the counter; go to ISSUE.
  - dec_obi_req_o.req=0.
- State ISSUE:
  - dec_obi_req_o.req=1 with the captured a-channel fields, held constant every cycle; core gnt=0.
  - Response accepted when dec gnt && dec rvalid are high in the same cycle:
    - capture rdata and err; write accesses store rdata as returned;
    - go to RESP; the counter stops.
  - Otherwise the counter increments by 1.
  - When TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1 with no response: capture err=1 and rdata=0, pulse timeout_o, go to RESP.
  - A decoder response arriving in the timeout cycle wins: the real data is used and timeout_o stays 0.
- State RESP:
  - core rvalid=1 for exactly one cycle, carrying the captured rdata and err, rid=captured aid, r_optional=0.
  - dec_obi_req_o.req=0.
  - Back-to-back: core gnt = core req in the same cycle. On req&gnt, capture the new access and go to ISSUE; else go to IDLE.
- Latency:
  - Best case: gnt at cycle 0, decoder hit at cycle 1, rvalid at cycle 2.
  - Sustained throughput: one access per 2 cycles.
- Outstanding accesses: exactly one; no buffering beyond that.
- Throughout: dec_obi_req_o.a.rid-related fields are zero except aid; the counter saturates and never wraps.

Decomposition:
- Shared package (magia_tile_pkg): IDMA_CTRL_TIMEOUT_CYCLES default constant.
- State enum: idma_ctrl_ser_state_e {IDLE, ISSUE, RESP}, defined local to the module.
- No sub-module is needed: one FSM, one capture register bank, one counter.
- Integration: the top level instantiates it in front of idma_obi_ctrl_decoder.

Test Plan:
1. Write 0x0000_0040 to CONFIG; the decoder answers in the first ISSUE cycle. Required: gnt at T0, dec req at T1, core rvalid at T2 with err=0 and rid=aid; dec req low at T2.
2. Read LENGTH_LOW with the frontend ready delayed 5 cycles and returning 0x0000_1000. Required: dec fields stable for all 6 ISSUE cycles; rvalid one cycle after the response with rdata=0x1000 and err=0.
3. Read an undecoded offset 0x0C8 (the decoder never grants) with TIMEOUT_CYCLES=8. Required: timeout_o pulses at ISSUE cycle 8; rvalid next cycle with err=1 and rdata=0; busy_o then falls.
4. Core req held high for 4 back-to-back accesses with aid 1..4. Required: gnt in the IDLE/RESP cycles only; rvalid every 2nd cycle with rid 1,2,3,4 in order.
5. Assert rst_ni=0 during ISSUE of a read. Required: outputs zero immediately, no rvalid after release, and the next access completes normally.
6. TIMEOUT_CYCLES=4 with the decoder response arriving in ISSUE cycle 4. Required: real rdata is returned, err=0, and timeout_o never pulses.
